// File: rtl/rob_param_pkg.sv
// Shared reorder-buffer definitions: opcode constants, store FSM encoding,
// entry payload layout and opcode class helpers (also used by rs/lsb).
package rob_pkg;

    // Control-transfer opcodes (contiguous BEQ..BGEU range plus JALR)
    localparam logic [5:0] BEQ  = 6'h18;
    localparam logic [5:0] BNE  = 6'h19;
    localparam logic [5:0] BLT  = 6'h1a;
    localparam logic [5:0] BGE  = 6'h1b;
    localparam logic [5:0] BLTU = 6'h1c;
    localparam logic [5:0] BGEU = 6'h1d;
    localparam logic [5:0] JALR = 6'h1e;

    // Store opcodes (contiguous SB..SW range)
    localparam logic [5:0] SB   = 6'h20;
    localparam logic [5:0] SH   = 6'h21;
    localparam logic [5:0] SW   = 6'h22;

    // Tag value meaning "no entry" for consumers that track producers
    localparam logic [5:0] ENTRY_NULL = 6'h3f;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } st_state_t;

    // Per-entry payload; the valid bit lives separately so only it needs reset
    typedef struct packed {
        logic        ready;
        logic [5:0]  op;
        logic [5:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc_pred;
        logic [31:0] value;
        logic [31:0] pc_real;
        logic [31:0] addr;
    } rob_entry_t;

    function automatic logic is_ctrl(input logic [5:0] op);
        return ((op >= BEQ) && (op <= BGEU)) || (op == JALR);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op >= SB) && (op <= SW);
    endfunction

endpackage

// File: rtl/rob_param_if.sv
// Reorder-buffer bus: allocation, writeback, commit, store and redirect.
// master = pipeline/memory side, slave = the ROB itself.
interface rob_param_if #(
    parameter int DEPTH = 32,
    parameter int NWB   = 3,
    parameter int EW    = $clog2(DEPTH)
);
    logic              alloc_valid;
    logic [5:0]        alloc_op;
    logic [5:0]        alloc_rd;
    logic [31:0]       alloc_pc;
    logic [31:0]       alloc_pc_pred;
    logic [EW-1:0]     alloc_entry;
    logic              full;
    logic              empty;
    logic [EW:0]       count;

    logic [NWB-1:0]    wb_valid;
    logic [NWB*EW-1:0] wb_entry;
    logic [NWB*32-1:0] wb_value;
    logic [NWB*32-1:0] wb_pc_real;
    logic [NWB*32-1:0] wb_addr;

    logic              commit_valid;
    logic [EW-1:0]     commit_entry;
    logic [5:0]        commit_rd;
    logic [31:0]       commit_value;

    logic              st_req;
    logic [5:0]        st_op;
    logic [31:0]       st_addr;
    logic [31:0]       st_data;
    logic              st_done;

    logic              br_commit;
    logic              br_mispred;
    logic [31:0]       br_pc;
    logic [31:0]       br_target;
    logic              flush;
    logic [31:0]       flush_pc;

    modport master (
        output alloc_valid, alloc_op, alloc_rd, alloc_pc, alloc_pc_pred,
        output wb_valid, wb_entry, wb_value, wb_pc_real, wb_addr, st_done,
        input  alloc_entry, full, empty, count,
        input  commit_valid, commit_entry, commit_rd, commit_value,
        input  st_req, st_op, st_addr, st_data,
        input  br_commit, br_mispred, br_pc, br_target, flush, flush_pc
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_rd, alloc_pc, alloc_pc_pred,
        input  wb_valid, wb_entry, wb_value, wb_pc_real, wb_addr, st_done,
        output alloc_entry, full, empty, count,
        output commit_valid, commit_entry, commit_rd, commit_value,
        output st_req, st_op, st_addr, st_data,
        output br_commit, br_mispred, br_pc, br_target, flush, flush_pc
    );
endinterface

// File: rtl/rob_param_store_ctrl.sv
// Store retirement: holds a store request stable until memory acknowledges,
// then tells the ROB to retire the head.
module rob_store_ctrl
    import rob_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic        st_done,
    output logic        st_req,
    output logic [5:0]  st_op,
    output logic [31:0] st_addr,
    output logic [31:0] st_data,
    output logic        busy,
    output logic        retire
);
    st_state_t state_q, state_d;

    assign busy = (state_q == ST_WAIT);

    // Next state: launch on a ready store head, retire on memory completion
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: if (rdy && start) state_d = ST_WAIT;
            ST_WAIT: if (rdy && st_done) begin
                state_d = ST_IDLE;
                retire  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any outstanding store
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Request registers: captured at launch and held until completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_req  <= 1'b0;
            st_op   <= '0;
            st_addr <= '0;
            st_data <= '0;
        end else if (state_q == ST_IDLE && state_d == ST_WAIT) begin
            st_req  <= 1'b1;
            st_op   <= op;
            st_addr <= addr;
            st_data <= data;
        end else if (retire) begin
            st_req  <= 1'b0;
        end
    end
endmodule

// File: rtl/rob_param.sv
// Parameterized reorder buffer: in-order allocate, multi-port writeback,
// in-order commit with branch resolution, flush and blocking store retire.
module rob_param
    import rob_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int NWB   = 3,
    parameter int EW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    rob_param_if.slave bus
);
    rob_entry_t       mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [EW-1:0]    head, tail;
    logic [EW:0]      count;

    logic [DEPTH-1:0] wb_hit;
    logic [31:0]      wb_val  [DEPTH];
    logic [31:0]      wb_real [DEPTH];
    logic [31:0]      wb_adr  [DEPTH];

    rob_entry_t head_e;
    logic head_ok, head_st, head_ctrl;
    logic commit_fire, mispred, alloc_fire, retire;
    logic st_start, st_busy, st_retire;

    assign head_e      = mem[head];
    assign head_ok     = vld[head] && head_e.ready;
    assign head_st     = is_store(head_e.op);
    assign head_ctrl   = is_ctrl(head_e.op);
    assign commit_fire = rdy && head_ok && !head_st && !st_busy;
    assign mispred     = commit_fire && head_ctrl && (head_e.pc_real != head_e.pc_pred);
    assign st_start    = head_ok && head_st && !st_busy;
    assign alloc_fire  = rdy && bus.alloc_valid && !bus.full;
    assign retire      = commit_fire || st_retire;

    assign bus.full        = (count == (EW+1)'(DEPTH));
    assign bus.empty       = (count == '0);
    assign bus.count       = count;
    assign bus.alloc_entry = tail;

    // Writeback merge: scan channels high to low so the lowest index wins a tag collision
    always_comb begin
        wb_hit = '0;
        for (int e = 0; e < DEPTH; e++) begin
            wb_val[e]  = '0;
            wb_real[e] = '0;
            wb_adr[e]  = '0;
            for (int c = NWB-1; c >= 0; c--) begin
                if (bus.wb_valid[c] && bus.wb_entry[c*EW +: EW] == EW'(e)) begin
                    wb_hit[e]  = 1'b1;
                    wb_val[e]  = bus.wb_value[c*32 +: 32];
                    wb_real[e] = bus.wb_pc_real[c*32 +: 32];
                    wb_adr[e]  = bus.wb_addr[c*32 +: 32];
                end
            end
        end
    end

    // Entry payload: allocation fills the tail, writeback readies live entries
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (vld[e] && wb_hit[e]) begin
                    mem[e].ready   <= 1'b1;
                    mem[e].value   <= wb_val[e];
                    mem[e].pc_real <= wb_real[e];
                    mem[e].addr    <= wb_adr[e];
                end
            end
            if (alloc_fire) begin
                mem[tail].ready   <= 1'b0;
                mem[tail].op      <= bus.alloc_op;
                mem[tail].rd      <= bus.alloc_rd;
                mem[tail].pc      <= bus.alloc_pc;
                mem[tail].pc_pred <= bus.alloc_pc_pred;
            end
        end
    end

    // Valid bits: a flush wipes everything, including same-cycle allocation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else if (rdy) begin
            if (mispred) begin
                vld <= '0;
            end else begin
                if (retire)     vld[head] <= 1'b0;
                if (alloc_fire) vld[tail] <= 1'b1;
            end
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (mispred) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + EW'(retire);
                tail  <= tail + EW'(alloc_fire);
                count <= count + (EW+1)'(alloc_fire) - (EW+1)'(retire);
            end
        end
    end

    // Commit / predictor / redirect outputs: pulses follow events, payloads hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.commit_valid <= 1'b0;
            bus.commit_entry <= '0;
            bus.commit_rd    <= '0;
            bus.commit_value <= '0;
            bus.br_commit    <= 1'b0;
            bus.br_mispred   <= 1'b0;
            bus.br_pc        <= '0;
            bus.br_target    <= '0;
            bus.flush        <= 1'b0;
            bus.flush_pc     <= '0;
        end else if (rdy) begin
            bus.commit_valid <= commit_fire;
            bus.br_commit    <= commit_fire && head_ctrl;
            bus.br_mispred   <= mispred;
            bus.flush        <= mispred;
            if (commit_fire) begin
                bus.commit_entry <= head;
                bus.commit_rd    <= head_e.rd;
                bus.commit_value <= head_e.value;
            end
            if (commit_fire && head_ctrl) begin
                bus.br_pc     <= head_e.pc;
                bus.br_target <= head_e.pc_real;
            end
            if (mispred) bus.flush_pc <= head_e.pc_real;
        end
    end

    rob_store_ctrl u_st (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .start   (st_start),
        .op      (head_e.op),
        .addr    (head_e.addr),
        .data    (head_e.value),
        .st_done (bus.st_done),
        .st_req  (bus.st_req),
        .st_op   (bus.st_op),
        .st_addr (bus.st_addr),
        .st_data (bus.st_data),
        .busy    (st_busy),
        .retire  (st_retire)
    );
endmodule

// File: tb/tb_rob_param.sv
// Directed + randomized bench for rob_param against a queue-based ROB model.
module tb_rob_param;
    import rob_pkg::*;

    localparam int DEPTH = 4;
    localparam int NWB   = 3;
    localparam int EW    = 2;
    localparam logic [5:0] ADD = 6'h01;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b0;
    int total = 0;
    int bad   = 0;

    rob_param_if #(.DEPTH(DEPTH), .NWB(NWB), .EW(EW)) bus ();
    rob_param #(.DEPTH(DEPTH), .NWB(NWB), .EW(EW)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

    always #5 clk = ~clk;

    // Model: in-flight instructions in program order, oldest first
    typedef struct {
        int          tag;
        logic [5:0]  op;
        logic [5:0]  rd;
        logic [31:0] pc;
        logic [31:0] pred;
        bit          done;
        logic [31:0] val;
        logic [31:0] real_pc;
        logic [31:0] addr;
    } ment_t;

    ment_t q[$];
    int    mtail;
    bit    st_wait;
    logic        e_cv, e_brc, e_brm, e_fl, e_sr;
    logic [EW-1:0] e_ce;
    logic [5:0]  e_crd, e_sop;
    logic [31:0] e_cval, e_bpc, e_btg, e_fpc, e_sa, e_sd;

    function automatic bit ctrl_op(input logic [5:0] op);
        return op inside {BEQ, BNE, BLT, BGE, BLTU, BGEU, JALR};
    endfunction

    function automatic bit store_op(input logic [5:0] op);
        return op inside {SB, SH, SW};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mtail = 0; st_wait = 0;
        e_cv = 0; e_brc = 0; e_brm = 0; e_fl = 0; e_sr = 0;
        e_ce = '0; e_crd = '0; e_sop = '0;
        e_cval = '0; e_bpc = '0; e_btg = '0; e_fpc = '0; e_sa = '0; e_sd = '0;
    endtask

    task automatic idle_inputs();
        bus.alloc_valid = 1'b0; bus.alloc_op = '0; bus.alloc_rd = '0;
        bus.alloc_pc = '0; bus.alloc_pc_pred = '0;
        bus.wb_valid = '0; bus.wb_entry = '0; bus.wb_value = '0;
        bus.wb_pc_real = '0; bus.wb_addr = '0;
        bus.st_done = 1'b0;
    endtask

    task automatic set_alloc(input logic [5:0] op, input logic [5:0] rd, input logic [31:0] pc, input logic [31:0] pred);
        bus.alloc_valid = 1'b1; bus.alloc_op = op; bus.alloc_rd = rd;
        bus.alloc_pc = pc; bus.alloc_pc_pred = pred;
    endtask

    task automatic set_wb(input int c, input int tag, input logic [31:0] val, input logic [31:0] rpc, input logic [31:0] adr);
        bus.wb_valid[c] = 1'b1;
        bus.wb_entry[c*EW +: EW] = EW'(tag);
        bus.wb_value[c*32 +: 32] = val;
        bus.wb_pc_real[c*32 +: 32] = rpc;
        bus.wb_addr[c*32 +: 32] = adr;
    endtask

    // One clock edge of the ROB rules, evaluated on the pre-edge inputs
    task automatic model_step();
        int nq; int t; bit commit; bit fl; bit sdone; bit [DEPTH-1:0] seen; ment_t m;
        nq = q.size(); commit = 0; fl = 0; sdone = 0; seen = '0;
        e_cv = 0; e_brc = 0; e_brm = 0; e_fl = 0;
        if (st_wait) begin
            if (bus.st_done) sdone = 1;
        end else if (nq > 0 && q[0].done) begin
            if (store_op(q[0].op)) begin
                st_wait = 1; e_sr = 1; e_sop = q[0].op; e_sa = q[0].addr; e_sd = q[0].val;
            end else begin
                commit = 1; e_cv = 1; e_ce = EW'(q[0].tag); e_crd = q[0].rd; e_cval = q[0].val;
                if (ctrl_op(q[0].op)) begin
                    e_brc = 1; e_bpc = q[0].pc; e_btg = q[0].real_pc;
                    if (q[0].real_pc != q[0].pred) begin
                        e_brm = 1; e_fl = 1; e_fpc = q[0].real_pc; fl = 1;
                    end
                end
            end
        end
        if (fl) begin
            q.delete(); mtail = 0;
            return;
        end
        for (int c = 0; c < NWB; c++) begin
            if (bus.wb_valid[c]) begin
                t = int'(bus.wb_entry[c*EW +: EW]);
                if (!seen[t]) begin
                    seen[t] = 1;
                    foreach (q[i]) if (q[i].tag == t) begin
                        q[i].done = 1; q[i].val = bus.wb_value[c*32 +: 32];
                        q[i].real_pc = bus.wb_pc_real[c*32 +: 32]; q[i].addr = bus.wb_addr[c*32 +: 32];
                    end
                end
            end
        end
        if (commit || sdone) void'(q.pop_front());
        if (sdone) begin st_wait = 0; e_sr = 0; end
        if (bus.alloc_valid && nq < DEPTH) begin
            m.tag = mtail; m.op = bus.alloc_op; m.rd = bus.alloc_rd; m.pc = bus.alloc_pc;
            m.pred = bus.alloc_pc_pred; m.done = 0; m.val = '0; m.real_pc = '0; m.addr = '0;
            q.push_back(m);
            mtail = (mtail + 1) % DEPTH;
        end
    endtask

    task automatic check_outputs();
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
        chk("alloc_entry", 32'(bus.alloc_entry), 32'(mtail));
        chk("commit_valid", 32'(bus.commit_valid), 32'(e_cv));
        if (e_cv) begin
            chk("commit_entry", 32'(bus.commit_entry), 32'(e_ce));
            chk("commit_rd", 32'(bus.commit_rd), 32'(e_crd));
            chk("commit_value", bus.commit_value, e_cval);
        end
        chk("br_commit", 32'(bus.br_commit), 32'(e_brc));
        chk("br_mispred", 32'(bus.br_mispred), 32'(e_brm));
        chk("flush", 32'(bus.flush), 32'(e_fl));
        if (e_brc) begin
            chk("br_pc", bus.br_pc, e_bpc);
            chk("br_target", bus.br_target, e_btg);
        end
        if (e_fl) chk("flush_pc", bus.flush_pc, e_fpc);
        chk("st_req", 32'(bus.st_req), 32'(e_sr));
        if (e_sr) begin
            chk("st_op", 32'(bus.st_op), 32'(e_sop));
            chk("st_addr", bus.st_addr, e_sa);
            chk("st_data", bus.st_data, e_sd);
        end
    endtask

    task automatic cyc();
        if (rdy) model_step();
        @(posedge clk); #1;
        check_outputs();
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        check_outputs();
        chk("rst_commit_entry", 32'(bus.commit_entry), 0);
        chk("rst_commit_value", bus.commit_value, 0);
        chk("rst_flush_pc", bus.flush_pc, 0);
        chk("rst_br_pc", bus.br_pc, 0);
        chk("rst_st_data", bus.st_data, 0);
        rst = 1'b1;
    endtask

    initial begin
        int tg; int idx; logic [5:0] op; logic [31:0] pc; logic [31:0] rpc;
        idle_inputs();
        model_reset();
        rdy = 1'b1;
        #2;
        do_reset();

        // Fill to DEPTH, overflow attempt, then retire one and wrap the tail
        for (int i = 0; i < 4; i++) begin
            set_alloc(ADD, 6'(i + 1), 32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i));
            cyc();
        end
        chk("s1_full", 32'(bus.full), 1);
        chk("s1_count", 32'(bus.count), 4);
        set_alloc(ADD, 6'd9, 32'h2000, 32'h2004);
        cyc();
        chk("s1_ovf_count", 32'(bus.count), 4);
        chk("s1_tail_wrap", 32'(bus.alloc_entry), 0);
        set_wb(0, 0, 32'h55, 32'h0, 32'h0);
        cyc();
        cyc();
        chk("s1_cv", 32'(bus.commit_valid), 1);
        chk("s1_commit_tag", 32'(bus.commit_entry), 0);
        chk("s1_not_full", 32'(bus.full), 0);
        chk("s1_alloc_entry", 32'(bus.alloc_entry), 0);
        set_alloc(ADD, 6'd10, 32'h2000, 32'h2004);
        cyc();
        chk("s1_wrap_alloc", 32'(bus.alloc_entry), 1);

        // Three channels, out-of-order tags, in-order commit
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(ADD, 6'(i + 1), 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i));
            cyc();
        end
        set_wb(0, 1, 32'h11, 0, 0);
        set_wb(1, 2, 32'h22, 0, 0);
        set_wb(2, 0, 32'h33, 0, 0);
        cyc();
        cyc();
        chk("s2_c0_tag", 32'(bus.commit_entry), 0);
        chk("s2_c0_val", bus.commit_value, 32'h33);
        cyc();
        chk("s2_c1_tag", 32'(bus.commit_entry), 1);
        chk("s2_c1_val", bus.commit_value, 32'h11);
        cyc();
        chk("s2_c2_tag", 32'(bus.commit_entry), 2);
        chk("s2_c2_val", bus.commit_value, 32'h22);
        cyc();
        chk("s2_drained", 32'(bus.empty), 1);

        // Same-tag collision favours channel 0
        do_reset();
        set_alloc(ADD, 6'd3, 32'h40, 32'h44);
        cyc();
        set_wb(0, 0, 32'hAA, 0, 0);
        set_wb(2, 0, 32'hBB, 0, 0);
        cyc();
        cyc();
        chk("s3_collision", bus.commit_value, 32'hAA);

        // Mispredicted BEQ at head with three younger entries
        do_reset();
        set_alloc(BEQ, 6'd0, 32'h80, 32'h100);
        cyc();
        for (int i = 0; i < 3; i++) begin
            set_alloc(ADD, 6'(i + 4), 32'h84 + 32'(4 * i), 32'h88 + 32'(4 * i));
            cyc();
        end
        set_wb(0, 0, 32'h0, 32'h200, 32'h0);
        cyc();
        cyc();
        chk("s4_flush", 32'(bus.flush), 1);
        chk("s4_flush_pc", bus.flush_pc, 32'h200);
        chk("s4_mispred", 32'(bus.br_mispred), 1);
        chk("s4_count", 32'(bus.count), 0);
        chk("s4_empty", 32'(bus.empty), 1);
        cyc();
        chk("s4_flush_drop", 32'(bus.flush), 0);

        // SW at head blocks a younger ready entry until st_done
        do_reset();
        set_alloc(SW, 6'd0, 32'h300, 32'h304);
        cyc();
        set_alloc(ADD, 6'd5, 32'h304, 32'h308);
        cyc();
        set_wb(0, 0, 32'hDEADBEEF, 0, 32'h1000);
        set_wb(1, 1, 32'h77, 0, 0);
        cyc();
        cyc();
        chk("s5_st_req", 32'(bus.st_req), 1);
        chk("s5_st_addr", bus.st_addr, 32'h1000);
        chk("s5_st_data", bus.st_data, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("s5_st_hold", 32'(bus.st_req), 1);
            chk("s5_no_commit", 32'(bus.commit_valid), 0);
        end
        bus.st_done = 1'b1;
        cyc();
        chk("s5_st_drop", 32'(bus.st_req), 0);
        chk("s5_count", 32'(bus.count), 1);
        cyc();
        chk("s5_young_cv", 32'(bus.commit_valid), 1);
        chk("s5_young_val", bus.commit_value, 32'h77);

        // Reset in the middle of a store wait
        tg = mtail;
        set_alloc(SW, 6'd0, 32'h400, 32'h404);
        cyc();
        set_wb(0, tg, 32'h12345678, 0, 32'h2000);
        cyc();
        cyc();
        chk("s6_st_req", 32'(bus.st_req), 1);
        cyc();
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("s6_async_clr", 32'(bus.st_req), 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        cyc();
        chk("s6_after_rst", 32'(bus.st_req), 0);

        // Randomized traffic with stalls, stores, branches and stray writebacks
        do_reset();
        repeat (600) begin
            rdy = ($urandom_range(9) != 0);
            if ($urandom_range(1) == 1) begin
                case ($urandom_range(9))
                    0, 1, 2: op = ADD;
                    3: op = BEQ;
                    4: op = BNE;
                    5: op = BGEU;
                    6: op = JALR;
                    7: op = SB;
                    8: op = SW;
                    default: op = 6'h05;
                endcase
                pc = 32'($urandom_range(255)) << 2;
                set_alloc(op, 6'($urandom_range(63)), pc, pc + 32'd4);
            end
            for (int c = 0; c < NWB; c++) begin
                if ($urandom_range(99) < 35) begin
                    if (q.size() > 0 && $urandom_range(4) != 0) begin
                        idx = $urandom_range(q.size() - 1);
                        tg  = q[idx].tag;
                        rpc = ($urandom_range(2) == 0) ? q[idx].pred + 32'h40 : q[idx].pred;
                    end else begin
                        tg  = $urandom_range(DEPTH - 1);
                        rpc = $urandom;
                    end
                    set_wb(c, tg, $urandom, rpc, $urandom);
                end
            end
            bus.st_done = ($urandom_range(3) == 0);
            cyc();
        end
        rdy = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
